// File: rtl/nes_cpu_bus_responder.sv
// CPU-side bus responder for an NES core: decodes each CPU access into internal RAM,
// PPU register, PRG ROM or unmapped space and returns a one-cycle mem_ready pulse.
module nes_cpu_bus_responder #(
    parameter int unsigned PPU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  mem_data_out,
    input  logic        rw_n,
    input  logic        memory_access,
    output logic [7:0]  mem_data_in,
    output logic        mem_ready,
    output logic        bus_err,
    output logic        ppu_req,
    output logic        ppu_rw_n,
    output logic [2:0]  ppu_reg_sel,
    output logic [7:0]  ppu_wr_data,
    input  logic        ppu_ack,
    input  logic [7:0]  ppu_rd_data,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_data
);

    // Counter only has to reach PPU_TIMEOUT-1; the timeout fires on that edge.
    localparam int unsigned CntW = (PPU_TIMEOUT > 1) ? $clog2(PPU_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRam,
        StRomWait,
        StRomCap,
        StPpuWait,
        StDone
    } state_t;

    state_t state_q, state_d;

    // Region is folded into the next state at acceptance, so only the RAM index is kept.
    logic [10:0]     ram_idx_q;
    logic            rw_n_q;
    logic [7:0]      wdata_q;
    logic [CntW-1:0] cnt_q;
    logic            ppu_timeout;

    logic [7:0] ram [2048];

    // Ack wins over timeout when both land on the same edge.
    assign ppu_timeout = !ppu_ack && (cnt_q == CntW'(PPU_TIMEOUT - 1));
    assign mem_ready   = (state_q == StDone);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; requests are only looked at in idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (memory_access) begin
                    if (addr_bus[15]) begin
                        state_d = StRomWait;
                    end else if (addr_bus[14:13] == 2'b00) begin
                        state_d = StRam;
                    end else if (addr_bus[14:13] == 2'b01) begin
                        state_d = StPpuWait;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRam:     state_d = StDone;
            StRomWait: state_d = StRomCap;
            StRomCap:  state_d = StDone;
            StPpuWait: begin
                if (ppu_ack || ppu_timeout) begin
                    state_d = StDone;
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Request latch, PPU handshake, ROM address and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_idx_q   <= '0;
            rw_n_q      <= 1'b1;
            wdata_q     <= '0;
            cnt_q       <= '0;
            mem_data_in <= '0;
            bus_err     <= 1'b0;
            ppu_req     <= 1'b0;
            ppu_rw_n    <= 1'b1;
            ppu_reg_sel <= '0;
            ppu_wr_data <= '0;
            prg_addr    <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (memory_access) begin
                        ram_idx_q <= addr_bus[10:0];
                        rw_n_q    <= rw_n;
                        wdata_q   <= mem_data_out;
                        if (addr_bus[15]) begin
                            prg_addr <= addr_bus[14:0];
                        end
                        if (addr_bus[15:13] == 3'b001) begin
                            ppu_req     <= 1'b1;
                            ppu_rw_n    <= rw_n;
                            ppu_reg_sel <= addr_bus[2:0];
                            ppu_wr_data <= mem_data_out;
                            cnt_q       <= '0;
                        end
                    end
                end
                StRam: begin
                    if (rw_n_q) begin
                        mem_data_in <= ram[ram_idx_q];
                    end
                end
                StRomCap: begin
                    // ROM writes fall through with mem_data_in untouched
                    if (rw_n_q) begin
                        mem_data_in <= prg_data;
                    end
                end
                StPpuWait: begin
                    if (ppu_ack) begin
                        ppu_req <= 1'b0;
                        if (rw_n_q) begin
                            mem_data_in <= ppu_rd_data;
                        end
                    end else if (ppu_timeout) begin
                        // Open bus: mem_data_in keeps its previous value
                        ppu_req <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Internal RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == StRam && !rw_n_q) begin
            ram[ram_idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// Scoreboard bench for nes_cpu_bus_responder: the driver pushes the expected response of
// each access, a negedge monitor pops and compares on every mem_ready pulse.
module tb_nes_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] addr_bus = '0;
    logic [7:0]  mem_data_out = '0;
    logic        rw_n = 1'b1;
    logic        memory_access = 1'b0;
    logic [7:0]  mem_data_in;
    logic        mem_ready;
    logic        bus_err;
    logic        ppu_req;
    logic        ppu_rw_n;
    logic [2:0]  ppu_reg_sel;
    logic [7:0]  ppu_wr_data;
    logic        ppu_ack = 1'b0;
    logic [7:0]  ppu_rd_data = 8'hEE;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data = '0;

    nes_cpu_bus_responder #(.PPU_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_bus     (addr_bus),
        .mem_data_out (mem_data_out),
        .rw_n         (rw_n),
        .memory_access(memory_access),
        .mem_data_in  (mem_data_in),
        .mem_ready    (mem_ready),
        .bus_err      (bus_err),
        .ppu_req      (ppu_req),
        .ppu_rw_n     (ppu_rw_n),
        .ppu_reg_sel  (ppu_reg_sel),
        .ppu_wr_data  (ppu_wr_data),
        .ppu_ack      (ppu_ack),
        .ppu_rd_data  (ppu_rd_data),
        .prg_addr     (prg_addr),
        .prg_data     (prg_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        int unsigned acc;
        int unsigned lat;
        int unsigned req;
        logic [2:0]  sel;
        logic [14:0] prg;
        logic        rw;
        logic [7:0]  wd;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned rdy_total = 0;
    int unsigned req_cnt = 0;
    logic        seen_rw = 1'b1;
    logic [7:0]  seen_wd = '0;

    logic [2:0]  exp_sel = '0;
    logic [14:0] exp_prg = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // PPU model: acks after ack_delay cycles of ppu_req (0 = never)
    int unsigned ack_delay = 0;
    logic [7:0]  ppu_rd_val = '0;
    int unsigned ppu_cyc = 0;
    always @(negedge clk) begin
        if (ppu_req && rst_n) begin
            ppu_cyc++;
            ppu_ack = (ack_delay != 0) && (ppu_cyc == ack_delay);
            ppu_rd_data = ppu_ack ? ppu_rd_val : 8'hEE;
        end else begin
            ppu_cyc = 0;
            ppu_ack = 1'b0;
            ppu_rd_data = 8'hEE;
        end
    end

    // ROM model: data = addr[7:0] ^ 0xC0, one cycle after prg_addr
    logic [14:0] prg_prev = '0;
    always @(negedge clk) begin
        prg_data = prg_prev[7:0] ^ 8'hC0;
        prg_prev = prg_addr;
    end

    // Monitor: compare every completed access against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            req_cnt = 0;
        end else begin
            if (ppu_req) begin
                req_cnt++;
                seen_rw = ppu_rw_n;
                seen_wd = ppu_wr_data;
            end
            if (mem_ready) begin
                rdy_total++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: got pulse, want none");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rd_data", mem_data_in, mon_e.data);
                    chk("bus_err", bus_err, mon_e.err);
                    chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
                    chk("ppu_req_cycles", req_cnt, mon_e.req);
                    chk("ppu_reg_sel", ppu_reg_sel, mon_e.sel);
                    chk("prg_addr", prg_addr, mon_e.prg);
                    if (mon_e.req != 0) begin
                        chk("ppu_rw_n", seen_rw, mon_e.rw);
                        chk("ppu_wr_data", seen_wd, mon_e.wd);
                    end
                end
                req_cnt = 0;
            end else begin
                chk("bus_err_without_ready", bus_err, 1'b0);
            end
        end
    end

    task automatic push_exp(input logic [15:0] a, input logic r, input logic [7:0] wd,
                            input int unsigned acc, input logic [7:0] data,
                            input int unsigned lat, input int unsigned req, input logic err);
        exp_t e;
        if (a[15:13] == 3'b001) exp_sel = a[2:0];
        if (a[15]) exp_prg = a[14:0];
        e.data = data;
        e.err  = err;
        e.acc  = acc;
        e.lat  = lat;
        e.req  = req;
        e.sel  = exp_sel;
        e.prg  = exp_prg;
        e.rw   = r;
        e.wd   = wd;
        sbq.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            chk("completion_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    // One access: request held for a single edge, then dropped
    task automatic issue(input logic [15:0] a, input logic r, input logic [7:0] wd,
                         input int unsigned dly, input logic [7:0] rd,
                         input logic [7:0] data, input int unsigned lat,
                         input int unsigned req, input logic err);
        @(negedge clk);
        ack_delay = dly;
        ppu_rd_val = rd;
        addr_bus = a;
        rw_n = r;
        mem_data_out = wd;
        memory_access = 1'b1;
        push_exp(a, r, wd, cyc + 1, data, lat, req, err);
        @(posedge clk);
        #1 memory_access = 1'b0;
        wait_done();
    endtask

    task automatic check_reset_vals();
        chk("rst_mem_data_in", mem_data_in, 8'h00);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_ppu_req", ppu_req, 1'b0);
        chk("rst_ppu_rw_n", ppu_rw_n, 1'b1);
        chk("rst_ppu_reg_sel", ppu_reg_sel, 3'd0);
        chk("rst_ppu_wr_data", ppu_wr_data, 8'h00);
        chk("rst_prg_addr", prg_addr, 15'd0);
    endtask

    initial begin
        int unsigned acc0;
        int unsigned rdy_before;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // RAM write then mirrored read
        issue(16'h0012, 1'b0, 8'h5A, 0, 8'h00, 8'h00, 2, 0, 1'b0);
        issue(16'h1812, 1'b1, 8'h00, 0, 8'h00, 8'h5A, 2, 0, 1'b0);
        // ROM read
        issue(16'h8003, 1'b1, 8'h00, 0, 8'h00, 8'hC3, 3, 0, 1'b0);
        // PPU read, ack after 4 cycles
        issue(16'h200A, 1'b1, 8'h00, 4, 8'h80, 8'h80, 5, 4, 1'b0);
        // PPU read, no ack: timeout, open bus
        issue(16'h2002, 1'b1, 8'h00, 0, 8'h00, 8'h80, 17, 16, 1'b1);
        // PPU ack on the expiry edge counts as success
        issue(16'h2005, 1'b1, 8'h00, 16, 8'h3C, 8'h3C, 17, 16, 1'b0);
        // ROM write discarded, then unmapped read returns open bus
        issue(16'hC000, 1'b0, 8'h77, 0, 8'h00, 8'h3C, 3, 0, 1'b0);
        issue(16'h5000, 1'b1, 8'h00, 0, 8'h00, 8'h3C, 1, 0, 1'b0);
        // PPU write
        issue(16'h2007, 1'b0, 8'h99, 2, 8'h00, 8'h3C, 3, 2, 1'b0);

        // Back-to-back: request held high; inputs change mid-access and must be ignored
        @(negedge clk);
        addr_bus = 16'h07FF;
        rw_n = 1'b0;
        mem_data_out = 8'h11;
        memory_access = 1'b1;
        acc0 = cyc + 1;
        push_exp(16'h07FF, 1'b0, 8'h11, acc0, 8'h3C, 2, 0, 1'b0);
        @(posedge clk);
        #1;
        addr_bus = 16'h0FFF;
        rw_n = 1'b1;
        mem_data_out = 8'h00;
        push_exp(16'h0FFF, 1'b1, 8'h00, acc0 + 3, 8'h11, 2, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 memory_access = 1'b0;
        wait_done();

        // Reset in the middle of a PPU wait
        issue(16'h0100, 1'b0, 8'hA5, 0, 8'h00, 8'h11, 2, 0, 1'b0);
        @(negedge clk);
        ack_delay = 0;
        addr_bus = 16'h2001;
        rw_n = 1'b1;
        memory_access = 1'b1;
        @(posedge clk);
        #1 memory_access = 1'b0;
        repeat (5) @(negedge clk);
        rdy_before = rdy_total;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ppu_req", ppu_req, 1'b0);
        chk("rst_mid_ready", mem_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_sel = '0;
        exp_prg = '0;
        repeat (20) @(negedge clk);
        chk("no_ready_after_reset", rdy_total - rdy_before, 0);
        check_reset_vals();

        // RAM contents survive reset
        issue(16'h0100, 1'b1, 8'h00, 0, 8'h00, 8'hA5, 2, 0, 1'b0);
        issue(16'h1812, 1'b1, 8'h00, 0, 8'h00, 8'h5A, 2, 0, 1'b0);
        issue(16'hFFFF, 1'b1, 8'h00, 0, 8'h00, 8'h3F, 3, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nes_cpu_bus_responder.md
NES_CPU_BUS_RESPONDER -- requirements
Module: nes_cpu_bus_responder

Interface
REQ-001 Parameter PPU_TIMEOUT, default 16, max cycles waited for ppu_ack before the access is abandoned.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 addr_bus  input  16  CPU access address from the execute stage.
REQ-005 mem_data_out  input  8  CPU write data.
REQ-006 rw_n  input  1  1 = read, 0 = write.
REQ-007 memory_access  input  1  request level; a request is pending while high.
REQ-008 mem_data_in  output  8  registered read data returned to the CPU.
REQ-009 mem_ready  output  1  one-cycle pulse marking access completion.
REQ-010 bus_err  output  1  one-cycle pulse, coincident with mem_ready, on PPU timeout.
REQ-011 ppu_req / ppu_rw_n / ppu_reg_sel[2:0] / ppu_wr_data[7:0]  outputs  PPU register request, direction, register index and write data.
REQ-012 ppu_ack  input  1  PPU completion; ppu_rd_data  input  8  PPU read data, valid with ppu_ack.
REQ-013 prg_addr  output  15  cartridge PRG ROM address; prg_data  input  8  ROM data, valid one cycle after prg_addr.

Function
REQ-014 Memory map, decoded from the latched address:
- 0x0000-0x1FFF: internal 2 KB RAM, index addr[10:0] (mirrored x4).
- 0x2000-0x3FFF: PPU, ppu_reg_sel = addr[2:0] (mirrored every 8).
- 0x4000-0x7FFF: unmapped.
- 0x8000-0xFFFF: PRG ROM, prg_addr = addr[14:0].
REQ-015 FSM states: IDLE, RAM, ROM_WAIT, ROM_CAP, PPU_WAIT, DONE.
REQ-016 IDLE: memory_access=1 at a clock edge latches addr_bus, rw_n and mem_data_out, then moves to the state selected by region: RAM, ROM_WAIT, PPU_WAIT or DONE (unmapped).
REQ-017 RAM: a read loads mem_data_in from RAM[addr[10:0]]; a write stores the latched data. Then moves to DONE; mem_ready is high in the cycle after this edge (2 cycles after acceptance).
REQ-018 ROM_WAIT: prg_addr is registered at acceptance; the next cycle moves to ROM_CAP. ROM_CAP captures prg_data into mem_data_in and moves to DONE (mem_ready 3 cycles after acceptance).
REQ-019 ROM writes are discarded: no state change, mem_data_in unchanged, same latency as a read.
REQ-020 PPU_WAIT: ppu_req=1 is held with stable ppu_rw_n, ppu_reg_sel and ppu_wr_data until ppu_ack is sampled high.
- On that edge: ppu_req drops, a read captures ppu_rd_data into mem_data_in, state moves to DONE.
REQ-021 PPU timeout: if ppu_ack is still low after PPU_TIMEOUT cycles in PPU_WAIT:
- ppu_req drops, mem_data_in is unchanged (open bus), state moves to DONE, and bus_err pulses with mem_ready.
REQ-022 Unmapped access: no side effects; mem_data_in keeps its last value (open bus); mem_ready is high one cycle after acceptance.
REQ-023 DONE: mem_ready=1 for exactly one cycle, then IDLE. A request still high in IDLE is accepted as a new access (back-to-back; minimum 3 cycles per RAM access).
REQ-024 Request inputs are ignored outside IDLE; a memory_access drop mid-access does not abort it.
REQ-025 ppu_ack arriving in the same cycle the timeout counter expires counts as a successful ack: data captured, bus_err=0.
REQ-026 ppu_ack while ppu_req=0 is ignored.

Reset
REQ-027 rst_n=0 forces, asynchronously:
- state=IDLE
- mem_data_in=0x00, mem_ready=0, bus_err=0
- ppu_req=0, ppu_rw_n=1, ppu_reg_sel=0, ppu_wr_data=0x00
- prg_addr=0, timeout counter=0
REQ-028 RAM contents are not cleared by reset.
REQ-029 Reset during any access, including PPU_WAIT, abandons that access with no mem_ready pulse.
REQ-030 After release, the first request is accepted at the first clock edge with memory_access=1.

Verification
REQ-031 Write 0x5A to 0x0012, then read 0x1812 -> mem_ready 2 cycles after each acceptance; read returns 0x5A (mirror).
REQ-032 Read 0x8003 with the ROM model returning 0xC3 for prg_addr 0x0003 -> prg_addr=0x0003; mem_data_in=0xC3 with mem_ready 3 cycles after acceptance.
REQ-033 Read 0x200A, PPU acks after 4 cycles with 0x80 -> ppu_reg_sel=2; ppu_req high 4 cycles; mem_data_in=0x80; bus_err=0.
REQ-034 Read 0x2002 with no ack, PPU_TIMEOUT=16 -> ppu_req drops after 16 cycles; mem_ready and bus_err pulse together; mem_data_in holds the prior value.
REQ-035 Write 0x77 to 0xC000, then read 0x5000 -> no ROM or PPU activity; the read returns the last mem_data_in (open bus); mem_ready pulses for both accesses.
REQ-036 Assert rst_n=0 during PPU_WAIT -> ppu_req=0 immediately, no mem_ready; RAM data written before reset still reads back correctly.
